dff_share_arbiter: RTL

// - Round-robin scheduler sharing one DATA_W-bit capture register among N_REQ requesters.
// - Each requester drives its own data slice and raises a request. The block grants one

---
 rtl/dff_share_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter that shares one DATA_W-bit capture register among N_REQ requesters.
// Optional macro DFF_ARB_BACK2BACK_EN lets CAP re-arbitrate directly into GNT.
module dff_share_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int IDX_W  = $clog2(N_REQ)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ*DATA_W-1:0] i_d,
    output logic [N_REQ-1:0]        o_gnt,
    output logic [IDX_W-1:0]        o_owner,
    output logic [DATA_W-1:0]       o_q,
    output logic                    o_valid,
    output logic [1:0]              o_dbg_state
);

    // Handshake: requester k holds i_req[k] until it sees o_gnt[k] followed by o_valid.
    // A request dropped while granted withdraws it: no capture, and the pointer is unchanged.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT  = 2'b01,
        CAP  = 2'b10
    } state_t;

    state_t              state, state_n;
    logic [IDX_W-1:0]    ptr, ptr_n, ptr_after;
    logic [N_REQ-1:0]    gnt_n;
    logic [IDX_W-1:0]    owner_n;
    logic [DATA_W-1:0]   q_n;
    logic                valid_n;
    logic [DATA_W-1:0]   slice [N_REQ];

    for (genvar k = 0; k < N_REQ; k++) begin : g_slice
        assign slice[k] = i_d[k*DATA_W +: DATA_W];
    end

    // First set request searching start, start+1, ... wrapping modulo N_REQ.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [IDX_W-1:0] start);
        logic [IDX_W-1:0] idx;
        rr_pick = start;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = IDX_W'((int'(start) + i) % N_REQ);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    assign ptr_after   = (o_owner == IDX_W'(N_REQ - 1)) ? '0 : o_owner + 1'b1;
    assign o_dbg_state = state;

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        gnt_n   = o_gnt;
        owner_n = o_owner;
        q_n     = o_q;
        valid_n = 1'b0;
        case (state)
            IDLE: begin
                if (|i_req) begin
                    owner_n = rr_pick(i_req, ptr);
                    gnt_n   = onehot(owner_n);
                    state_n = GNT;
                end
            end
            GNT: begin
                if (i_req[o_owner]) begin
                    q_n     = slice[o_owner];
                    valid_n = 1'b1;
                    state_n = CAP;
                end else begin
                    gnt_n   = '0;
                    state_n = IDLE;
                end
            end
            CAP: begin
                gnt_n   = '0;
                ptr_n   = ptr_after;
                state_n = IDLE;
`ifdef DFF_ARB_BACK2BACK_EN
                // Searching from owner+1 puts the just-served bit last, so it only wins alone.
                if (|i_req) begin
                    owner_n = rr_pick(i_req, ptr_after);
                    gnt_n   = onehot(owner_n);
                    state_n = GNT;
                end
`endif
            end
            default: begin
                gnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            ptr     <= '0;
            o_gnt   <= '0;
            o_owner <= '0;
            o_q     <= '0;
            o_valid <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            o_gnt   <= gnt_n;
            o_owner <= owner_n;
            o_q     <= q_n;
            o_valid <= valid_n;
        end
    end

endmodule
